// File: rtl/ser_to_sym_pkg.sv
// Shared types and helpers for the serial-to-symbol packer.
// Contents: FSM state enum, width of the bps_sel port for a given MAX_BPS,
//           and the bit placement index inside a symbol.
package ser_to_sym_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // bps_sel must be able to hold MAX_BPS itself, plus illegal values above it
    function automatic int bps_sel_width(input int max_bps);
        return $clog2(max_bps) + 1;
    endfunction

    // Symbol bit index for the k-th received bit of a symbol
    function automatic int place_idx(input int k, input int bps, input bit msb_first);
        return msb_first ? (bps - 1 - k) : k;
    endfunction

endpackage

// File: rtl/ser_to_sym_sync_fifo.sv
// Small synchronous FIFO with async active-high reset.
// Ports: clk, rst; push/push_data write side; pop read side;
//        head = current oldest entry, full/empty flags from the registered count.
// The head is read straight out of the storage registers, so it only changes
// on a clock edge and there is no combinational path from push/pop to it.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ser_to_sym.sv
// Serial-to-symbol packer: one bit per accepted beat, BPS bits per symbol,
// symbols queued in an output FIFO.
// Ports: clk, rst (async, active high); bps_sel latched on SOF;
//        in_valid/in_bit/in_sof/in_eof/in_ready serial input handshake;
//        sym_valid/sym_data/sym_ready symbol output handshake;
//        align_err one-cycle pulse on SOF mid-symbol; cfg_err sticky bad bps_sel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for SOF; non-SOF beats are accepted and dropped
// COLLECT | inside a frame, packing bits into the current symbol
module ser_to_sym
    import ser_to_sym_pkg::*;
#(
    parameter int MAX_BPS    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [bps_sel_width(MAX_BPS)-1:0] bps_sel,
    input  logic                              in_valid,
    input  logic                              in_bit,
    input  logic                              in_sof,
    input  logic                              in_eof,
    output logic                              in_ready,
    output logic                              sym_valid,
    output logic [MAX_BPS-1:0]                sym_data,
    input  logic                              sym_ready,
    output logic                              align_err,
    output logic                              cfg_err
);
    localparam int              BW      = bps_sel_width(MAX_BPS);
    localparam logic [BW-1:0]   BPS_MAX = BW'(MAX_BPS);

    state_t             state;
    state_t             state_nxt;
    logic [BW-1:0]      bps_q;
    logic [BW-1:0]      bps_nxt;
    logic [BW-1:0]      cnt_q;
    logic [BW-1:0]      k_cur;
    logic [BW-1:0]      cnt_inc;
    logic [MAX_BPS-1:0] sreg_q;
    logic [MAX_BPS-1:0] sreg_nxt;
    logic               accept;
    logic               start;
    logic               store;
    logic               do_push;
    logic               sel_legal;
    logic               fifo_full;
    logic               fifo_empty;

    // in_ready comes only from the registered FIFO count
    assign in_ready  = ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign start     = accept & in_sof;
    assign store     = accept & (in_sof | (state == COLLECT));
    assign sel_legal = (bps_sel != '0) && (int'(bps_sel) <= MAX_BPS);
    assign sym_valid = ~fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (store) state_nxt = in_eof ? IDLE : COLLECT;
    end

    // SOF restarts the symbol from scratch with a freshly latched BPS,
    // whatever was in flight; the bit is then placed against that BPS.
    always_comb begin
        bps_nxt = bps_q;
        k_cur   = cnt_q;
        sreg_nxt = sreg_q;
        if (in_sof) begin
            bps_nxt  = sel_legal ? bps_sel : BPS_MAX;
            k_cur    = '0;
            sreg_nxt = '0;
        end
        for (int i = 0; i < MAX_BPS; i++) begin
            if (i == place_idx(int'(k_cur), int'(bps_nxt), MSB_FIRST)) sreg_nxt[i] = in_bit;
        end
        cnt_inc = k_cur + 1'b1;
        // after storing, count is always nonzero, so EOF always flushes
        do_push = store & (in_eof | (cnt_inc == bps_nxt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bps_q     <= BPS_MAX;
            cnt_q     <= '0;
            sreg_q    <= '0;
            align_err <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            align_err <= start & (state == COLLECT) & (cnt_q != '0);
            if (start & ~sel_legal) cfg_err <= 1'b1;
            if (store) begin
                bps_q  <= bps_nxt;
                cnt_q  <= do_push ? '0 : cnt_inc;
                sreg_q <= do_push ? '0 : sreg_nxt;
            end
        end
    end

    sync_fifo #(
        .WIDTH (MAX_BPS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .push_data (sreg_nxt),
        .pop       (sym_ready),
        .head      (sym_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_ser_to_sym.sv
// Drives one stimulus stream into two packers (MSB-first and LSB-first)
// and scoreboards the symbols each produces.
module tb_ser_to_sym;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] bps_sel = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_eof = 1'b0;
    logic       sym_ready = 1'b1;

    logic       in_ready_m, sym_valid_m, align_m, cfg_m;
    logic [3:0] sym_data_m;
    logic       in_ready_l, sym_valid_l, align_l, cfg_l;
    logic [3:0] sym_data_l;

    int         n_checks = 0;
    int         n_fail = 0;
    int         align_cnt = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    always #5 clk = ~clk;

    ser_to_sym #(.MAX_BPS(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bps_sel(bps_sel), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_eof(in_eof), .in_ready(in_ready_m), .sym_valid(sym_valid_m),
        .sym_data(sym_data_m), .sym_ready(sym_ready), .align_err(align_m), .cfg_err(cfg_m)
    );

    ser_to_sym #(.MAX_BPS(4), .FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bps_sel(bps_sel), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .in_eof(in_eof), .in_ready(in_ready_l), .sym_valid(sym_valid_l),
        .sym_data(sym_data_l), .sym_ready(sym_ready), .align_err(align_l), .cfg_err(cfg_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs sampled at negedge: valid & ready here means a pop at the next posedge
    always @(negedge clk) begin
        if (!rst) begin
            align_cnt += int'(align_m);
            if (sym_valid_m && sym_ready) begin
                check("sym_m_expected", 32'(q_m.size() != 0), 32'd1);
                if (q_m.size() != 0) check("sym_m", 32'(sym_data_m), 32'(q_m.pop_front()));
            end
            if (sym_valid_l && sym_ready) begin
                check("sym_l_expected", 32'(q_l.size() != 0), 32'd1);
                if (q_l.size() != 0) check("sym_l", 32'(sym_data_l), 32'(q_l.pop_front()));
            end
        end
    end

    // One beat; returns #1 after the edge that accepted it
    task automatic beat(input logic b, input logic sof, input logic eof, input logic [2:0] sel);
        int guard = 0;
        in_valid = 1'b1; in_bit = b; in_sof = sof; in_eof = eof; bps_sel = sel;
        @(negedge clk);
        while (!in_ready_m && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("accept_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    endtask

    // Frame of n bits (bits[0] first). Expected symbols come from a plain
    // placement model for both bit orders; a trailing partial symbol without
    // EOF is not expected at the output.
    task automatic send(input logic [2:0] sel, input int bps, input int n,
                        input logic [15:0] bits, input bit expect_out = 1'b1,
                        input bit eof_last = 1'b1);
        int         k = 0;
        logic [3:0] vm = '0;
        logic [3:0] vl = '0;
        for (int i = 0; i < n; i++) begin
            vm = vm | (4'(bits[i]) << (bps - 1 - k));
            vl = vl | (4'(bits[i]) << k);
            k++;
            if (k == bps || (eof_last && i == n - 1)) begin
                if (expect_out) begin
                    q_m.push_back(vm);
                    q_l.push_back(vl);
                end
                k = 0; vm = '0; vl = '0;
            end
        end
        for (int i = 0; i < n; i++) beat(bits[i], i == 0, eof_last && i == n - 1, sel);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;

        // reset state
        #12;
        check("rst_in_ready", 32'(in_ready_m), 32'd1);
        check("rst_sym_valid", 32'(sym_valid_m), 32'd0);
        check("rst_sym_data", 32'(sym_data_m), 32'd0);
        check("rst_align", 32'(align_m), 32'd0);
        check("rst_cfg", 32'(cfg_m), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // DQPSK 1,1,0,0,1,1 with latency checks on the first symbol
        q_m.push_back(4'd3); q_m.push_back(4'd0); q_m.push_back(4'd3);
        q_l.push_back(4'd3); q_l.push_back(4'd0); q_l.push_back(4'd3);
        beat(1'b1, 1'b1, 1'b0, 3'd2);
        check("dqpsk_valid_early", 32'(sym_valid_m), 32'd0);
        beat(1'b1, 1'b0, 1'b0, 3'd2);
        check("dqpsk_valid_lat", 32'(sym_valid_m), 32'd1);
        check("dqpsk_data_lat", 32'(sym_data_m), 32'd3);
        beat(1'b0, 1'b0, 1'b0, 3'd2);
        beat(1'b0, 1'b0, 1'b0, 3'd2);
        beat(1'b1, 1'b0, 1'b0, 3'd2);
        beat(1'b1, 1'b0, 1'b1, 3'd2);
        idle(3);
        check("dqpsk_align", 32'(align_cnt), 32'd0);
        check("dqpsk_cfg", 32'(cfg_m), 32'd0);

        // 16QAM 1,0,1,1: 0xB msb-first, 0xD lsb-first
        send(3'd4, 4, 4, 16'h000D);
        idle(3);

        // padding: 1,0,1 then one-bit frame
        send(3'd4, 4, 3, 16'h0005);
        check("pad_state_idle", 32'(dut_m.state), 32'(ser_to_sym_pkg::IDLE));
        send(3'd4, 4, 1, 16'h0001);
        check("onebit_state_idle", 32'(dut_m.state), 32'(ser_to_sym_pkg::IDLE));
        idle(3);

        // backpressure with BPS=1
        sym_ready = 1'b0;
        q_m.push_back(4'd1); q_m.push_back(4'd0); q_m.push_back(4'd1);
        q_m.push_back(4'd1); q_m.push_back(4'd0);
        q_l.push_back(4'd1); q_l.push_back(4'd0); q_l.push_back(4'd1);
        q_l.push_back(4'd1); q_l.push_back(4'd0);
        beat(1'b1, 1'b1, 1'b0, 3'd1);
        beat(1'b0, 1'b0, 1'b0, 3'd1);
        beat(1'b1, 1'b0, 1'b0, 3'd1);
        check("bp_ready_before_full", 32'(in_ready_m), 32'd1);
        beat(1'b1, 1'b0, 1'b0, 3'd1);
        check("bp_ready_full", 32'(in_ready_m), 32'd0);
        fork
            beat(1'b0, 1'b0, 1'b1, 3'd1);
            begin
                repeat (3) @(negedge clk);
                check("bp_ready_held", 32'(in_ready_m), 32'd0);
                check("bp_head_held", 32'(sym_data_m), 32'd1);
                sym_ready = 1'b1;
            end
        join
        idle(8);
        check("bp_drained_m", 32'(q_m.size()), 32'd0);
        check("bp_drained_l", 32'(q_l.size()), 32'd0);

        // realignment: BPS=4 partial 1,1 dropped, new SOF with BPS=2
        base = align_cnt;
        send(3'd4, 4, 2, 16'h0003, 1'b1, 1'b0);
        q_m.push_back(4'd1); q_m.push_back(4'd2);
        q_l.push_back(4'd2); q_l.push_back(4'd1);
        beat(1'b0, 1'b1, 1'b0, 3'd2);
        check("align_pulse_m", 32'(align_m), 32'd1);
        check("align_pulse_l", 32'(align_l), 32'd1);
        beat(1'b1, 1'b0, 1'b0, 3'd2);
        check("align_pulse_end", 32'(align_m), 32'd0);
        beat(1'b1, 1'b0, 1'b0, 3'd2);
        beat(1'b0, 1'b0, 1'b1, 3'd2);
        idle(3);
        check("align_count", 32'(align_cnt - base), 32'd1);

        // illegal bps_sel = 0 clamps to 4 and sets sticky cfg_err
        send(3'd0, 4, 4, 16'h000D);
        check("cfg_set", 32'(cfg_m), 32'd1);
        send(3'd2, 2, 2, 16'h0001);
        idle(3);
        check("cfg_sticky", 32'(cfg_l), 32'd1);

        // reset mid-frame: 2 symbols queued, 3 of 4 bits in the shift register
        sym_ready = 1'b0;
        send(3'd4, 4, 11, 16'h05A5, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(sym_valid_m), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(sym_valid_m), 32'd0);
        check("rst_mid_ready", 32'(in_ready_m), 32'd1);
        check("rst_mid_cfg", 32'(cfg_m), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sym_ready = 1'b1;
        idle(1);
        send(3'd4, 4, 4, 16'h0006);

        guard = 0;
        while ((q_m.size() != 0 || q_l.size() != 0) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        idle(2);
        check("final_drain_m", 32'(q_m.size()), 32'd0);
        check("final_drain_l", 32'(q_l.size()), 32'd0);
        check("final_empty", 32'(sym_valid_m), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ser_to_sym.md
# ser_to_sym

Parametrised serial-to-symbol packer feeding the modulator symbol mapper. Accepts one bit per cycle under a valid/ready handshake and packs BPS bits into one symbol: BPS=1 for BPSK, 2 for DQPSK, 3 for 8PSK, 4 for 16QAM. BPS is selected at runtime, per frame. Symbols leave through a small output FIFO with valid/ready backpressure. Frame markers realign symbol boundaries, and a short final symbol is zero-padded.

## Interface
- MAX_BPS, 4: largest bits-per-symbol supported, range 1..8; sets the `sym_data` width.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.
- MSB_FIRST, 1: 1 puts the first received bit in symbol bit BPS-1; 0 puts it in bit 0.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- bps_sel  in  $clog2(MAX_BPS)+1  bits per symbol; sampled only on an accepted SOF beat.
- in_valid  in  1  `in_bit` is valid.
- in_bit  in  1  serial data bit.
- in_sof  in  1  first bit of a frame; qualified by `in_valid`.
- in_eof  in  1  last bit of a frame; qualified by `in_valid`. May coincide with `in_sof`.
- in_ready  out  1  bit accepted when `in_valid & in_ready`.
- sym_valid  out  1  FIFO head is valid.
- sym_data  out  MAX_BPS  symbol, right-aligned; bits at or above BPS are 0.
- sym_ready  in  1  symbol consumed when `sym_valid & sym_ready`.
- align_err  out  1  one-cycle pulse when an SOF arrives mid-symbol.
- cfg_err  out  1  sticky flag for an illegal `bps_sel` (0 or greater than MAX_BPS); cleared only by `rst`.

## Operation
- **State machine:** two states, IDLE and COLLECT. Reset state is IDLE.
- **IDLE:**
  - An accepted beat without SOF is discarded.
  - An accepted SOF beat does the following:
    - latches BPS from `bps_sel`; illegal values are clamped to MAX_BPS and set `cfg_err`;
    - clears the shift register;
    - stores the bit and sets count to 1;
    - moves to COLLECT.
- **COLLECT:** each accepted bit is stored and count is incremented.
  - When count reaches BPS, the symbol is pushed to the FIFO and count returns to 0.
  - BPS=1 pushes every bit.
- **Bit placement:** the k-th bit of a symbol (k=0..BPS-1) goes to index BPS-1-k when MSB_FIRST=1, and to index k when MSB_FIRST=0.
- **EOF:** the EOF bit is stored first. If count is then nonzero, the partial symbol is pushed with unfilled positions set to 0. The state returns to IDLE.
- **SOF in COLLECT:**
  - If count is nonzero, the partial symbol is dropped (not pushed) and `align_err` pulses.
  - In all cases the SOF handling from IDLE then applies, including re-latching BPS.
- **SOF and EOF on the same beat:** a one-bit frame; exactly one padded symbol is pushed; the state ends in IDLE.
- **Backpressure:** `in_ready = !fifo_full`. All beats are gated, including beats that would not complete a symbol. No data is ever lost.
- **Simultaneous push and pop** in one cycle with the FIFO full is impossible: `in_ready` is low, so no push occurs. Push and pop together in any other state leave the count unchanged.

## Timing
- **Reset values:**
  - `in_ready`=1, `sym_valid`=0, `sym_data`=0, `align_err`=0, `cfg_err`=0;
  - state IDLE, count 0, FIFO empty.
- **Reset mid-frame:** the partial symbol and all FIFO contents are discarded.
- **Latency:** a symbol completes on accept-edge N and `sym_valid` is high after edge N with the data stable. With the FIFO empty, that symbol is visible in the cycle after its last bit.
- **Throughput:** one bit per cycle sustained while `sym_ready`=1, i.e. one symbol every BPS cycles.
- **`sym_data`:** held stable while `sym_valid & !sym_ready`.
- **`in_ready`:** depends only on the registered FIFO count. There is no combinational path from `sym_ready` to `in_ready`.
- **`align_err`:** high for exactly the cycle after the offending SOF edge.

## Structure
- **Package `ser_to_sym_pkg`:**
  - state enum (IDLE, COLLECT);
  - function returning the `bps_sel` width for a given MAX_BPS;
  - function computing the placement index from k, BPS and MSB_FIRST.
- **Sub-module `sync_fifo`:**
  - parametrised by WIDTH and DEPTH;
  - registered head output, full/empty flags, asynchronous active-high reset.
  - Instantiated with WIDTH=MAX_BPS and DEPTH=FIFO_DEPTH.
- **Top level:** the control FSM, bit counter, shift/placement register and error flags.

## Test plan
- **DQPSK:** BPS=2, MSB_FIRST=1, bits 1,1,0,0,1,1 with SOF on the first bit and EOF on the last; `sym_ready`=1 → symbols 3, 0, 3, each valid one cycle after its second bit; no error flags.
- **16QAM, both orders:** BPS=4, bits 1,0,1,1.
  - MSB_FIRST=1 → symbol 0xB.
  - MSB_FIRST=0 → symbol 0xD.
- **Padding:** BPS=4, bits 1,0,1 with EOF on the third bit → 0xA. A one-bit frame with SOF=EOF=1, bit 1 → 0x8. FSM ends in IDLE both times.
- **Backpressure:** BPS=1, FIFO_DEPTH=4, `sym_ready`=0, continuous bits 1,0,1,1,0 → `in_ready` falls after the 4th accepted bit. Raising `sym_ready` drains 1,0,1,1 in order; the 5th bit (0) is then accepted and emitted. No loss or duplication.
- **Realignment and configuration errors:**
  - BPS=4, bits 1,1 followed by an SOF beat with `bps_sel`=2 → `align_err` pulses once and the partial symbol is absent from the output. The following symbols use BPS=2.
  - `bps_sel`=0 on an SOF → `cfg_err` sets, BPS clamps to 4, and the flag stays set until `rst`.
- **Reset mid-frame:** assert `rst` asynchronously after 3 of 4 bits with 2 symbols queued → immediately `sym_valid`=0 and `in_ready`=1. The next frame produces correct symbols.
